// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//
// Shares a single 8N1 UART transmit line between NUM_REQ byte producers.
// A round-robin arbiter picks one requester while the line is idle. The
// accepted byte is then sent in full: start bit, DATA_W data bits LSB first,
// and a stop bit. Only after that is the next byte granted. Bit timing comes
// from an external oversampling clock-enable: RATIO pulses make one bit.
//
// Parameters
//   NUM_REQ  number of requesters (>= 2)
//   DATA_W   data bits per frame
//   RATIO    CE pulses per bit period (must match the CE generator)
//
// Ports
//   clk_i         clock
//   rstn_i        asynchronous active-low reset
//   uart_ce_i     one-clk oversampling enable, RATIO pulses per bit
//   req_valid_i   per-requester byte valid, held until accepted
//   req_data_i    requester k's byte is [k*DATA_W +: DATA_W]
//   req_ready_o   one-hot accept strobe (only in IDLE, combinational)
//   tx_o          registered serial line, idle high
//   busy_o        high while a frame is in flight
//   gnt_id_o      index of the last/current granted requester
//   frame_done_o  one-clk pulse once the stop bit has completed
// ---------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int RATIO   = 8
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        uart_ce_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(NUM_REQ)-1:0]  gnt_id_o,
    output logic                        frame_done_o
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int TICK_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RATIO - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q;
    logic [TICK_W-1:0]   tick_q;
    logic [BIT_W-1:0]    bit_q;
    logic                tx_q;
    logic [ID_W-1:0]     gnt_q;
    logic [ID_W-1:0]     last_q;
    logic                done_q;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    int                  cand;
    logic [ID_W-1:0]     cand_id;
    logic                accept;
    logic                bit_end;

    // -----------------------------------------------------------------------
    // Round-robin search starting one past the last grant.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise paths that skip the assignment would infer a latch.
        win_found = 1'b0;
        win_id    = last_q;
        cand      = 0;
        cand_id   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_id = ID_W'(cand);
            if (!win_found && req_valid_i[cand_id]) begin
                win_found = 1'b1;
                win_id    = cand_id;
            end
        end
    end

    // Grants are withheld for the one IDLE cycle in which frame_done_o is
    // high, so the next ready appears the cycle after the done pulse and the
    // line stays high for at least one clk between frames.
    assign accept  = (state_q == ST_IDLE) && !done_q && win_found;

    // A bit period ends on the RATIO-th CE pulse counted in a busy state.
    assign bit_end = (state_q != ST_IDLE) && uart_ce_i && (tick_q == TICK_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every flop samples the values from before the clock edge.
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept)  state_d = ST_START;
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA:  if (bit_end && (bit_q == BIT_LAST)) state_d = ST_STOP;
            ST_STOP:  if (bit_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready_o = '0;
        // Gated by rstn_i so that no accept strobe leaks out during reset,
        // even though the arbiter sees live valids.
        if (accept && rstn_i) begin
            req_ready_o[win_id] = 1'b1;
        end
        busy_o = (state_q != ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // Datapath: capture, tick/bit counters, serializer, done pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: the shift register is reset as well even though it is
            // always reloaded before use; this keeps it free of X after reset.
            shift_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shift_q <= req_data_i[win_id*DATA_W +: DATA_W];
                gnt_q   <= win_id;
                last_q  <= win_id;
                tx_q    <= 1'b0;
                tick_q  <= '0;
                bit_q   <= '0;
            end else if ((state_q != ST_IDLE) && uart_ce_i) begin
                if (bit_end) begin
                    tick_q <= '0;
                end else begin
                    tick_q <= tick_q + 1'b1;
                end

                if (bit_end) begin
                    unique case (state_q)
                        ST_START: begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                        ST_DATA: begin
                            if (bit_q == BIT_LAST) begin
                                tx_q <= 1'b1;
                            end else begin
                                tx_q    <= shift_q[0];
                                shift_q <= shift_q >> 1;
                                bit_q   <= bit_q + 1'b1;
                            end
                        end
                        ST_STOP: begin
                            done_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign tx_o         = tx_q;
    assign gnt_id_o     = gnt_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Directed bench for uart_tx_sched with NUM_REQ=4, DATA_W=8, RATIO=8 and a
// CE pulse every 4 clk. Inputs are driven and outputs sampled 1-2 time units
// after the rising edge. Frame checks track the CE pulses clocked since the
// handshake. The expected line level is bit floor(n/8) of the 10-bit frame,
// and frame_done_o must appear when n reaches 80.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int RT = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              ce;
    logic [NR-1:0]     valid;
    logic [NR*DW-1:0]  data;
    logic [NR-1:0]     ready;
    logic              tx;
    logic              busy;
    logic [1:0]        gnt;
    logic              done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .RATIO   (RT)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .uart_ce_i    (ce),
        .req_valid_i  (valid),
        .req_data_i   (data),
        .req_ready_o  (ready),
        .tx_o         (tx),
        .busy_o       (busy),
        .gnt_id_o     (gnt),
        .frame_done_o (done)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; CE is a free-running 1-in-4 pulse.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        ce = (cyc % 4 == 0);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Wait for a ready strobe, check it, take the handshake edge and then
    // apply the valid vector that the producers present afterwards.
    task automatic wait_grant(input logic [3:0] exp_rdy, input int exp_id,
                              input int max_wait, input logic [3:0] next_valid,
                              input string tag);
        int waited;
        waited = 0;
        #1;
        while (ready === 4'b0000 && waited < 2000) begin
            step();
            waited++;
        end
        check({tag, "_wait"}, 32'(waited <= max_wait), 32'd1);
        check({tag, "_ready"}, 32'(ready), 32'(exp_rdy));
        step();
        check({tag, "_gnt_id"}, 32'(gnt), 32'(exp_id));
        check({tag, "_tx_start"}, 32'(tx), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        valid = next_valid;
    endtask

    // Follow one frame from the cycle after the handshake to the cycle
    // after frame_done_o.
    task automatic run_frame(input logic [7:0] b, input logic [3:0] glitch,
                             input bit scramble, input string tag);
        int n;
        int guard;
        int bad_tx;
        int bad_ctl;
        logic [9:0] obs;
        logic [9:0] expv;
        n = 0; guard = 0; bad_tx = 0; bad_ctl = 0; obs = '0;
        for (int i = 0; i < 10; i++) expv[i] = exp_bit(b, i);
        while (n < 80 && guard < 1000) begin
            if (tx !== exp_bit(b, n / 8)) bad_tx++;
            if (n % 8 == 4) obs[n / 8] = tx;
            if (done !== 1'b0 || busy !== 1'b1 || ready !== 4'b0000) bad_ctl++;
            if (ce) n++;
            if (guard == 10) valid = valid | glitch;
            if (guard == 11) valid = valid & ~glitch;
            if (scramble) data = {$urandom, $urandom} & 32'hFFFF_FFFF;
            step();
            guard++;
        end
        check({tag, "_bits"}, 32'(obs), 32'(expv));
        check({tag, "_tx_cycles_bad"}, 32'(bad_tx), 32'd0);
        check({tag, "_ctl_cycles_bad"}, 32'(bad_ctl), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_tx_idle"}, 32'(tx), 32'd1);
        check({tag, "_ready_holdoff"}, 32'(ready), 32'd0);
        step();
        check({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    task automatic advance_ce(input int k);
        int n;
        n = 0;
        while (n < k) begin
            if (ce) n++;
            step();
        end
    endtask

    initial begin
        int bad;
        rstn  = 1'b0;
        ce    = 1'b0;
        valid = 4'b1111;
        data  = 32'h4433_2211;

        // 1. Reset with all valids high.
        repeat (4) step();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // 2. Single byte 0xA5 from requester 2.
        valid = 4'b0000;
        data  = 32'h44A5_2211;
        rstn  = 1'b1;
        step();
        step();
        check("idle_no_req_ready", 32'(ready), 32'd0);
        valid = 4'b0100;
        wait_grant(4'b0100, 2, 0, 4'b0000, "t2");
        run_frame(8'hA5, 4'b0000, 1'b0, "t2");

        // 3. All four contend continuously from reset.
        rstn  = 1'b0;
        valid = 4'b1111;
        data  = 32'h4433_2211;
        step();
        step();
        rstn  = 1'b1;
        wait_grant(4'b0001, 0, 0, 4'b1111, "t3g0");
        run_frame(8'h11, 4'b0000, 1'b0, "t3f0");
        wait_grant(4'b0010, 1, 0, 4'b1111, "t3g1");
        run_frame(8'h22, 4'b0000, 1'b0, "t3f1");
        wait_grant(4'b0100, 2, 0, 4'b1111, "t3g2");
        run_frame(8'h33, 4'b0000, 1'b0, "t3f2");
        wait_grant(4'b1000, 3, 0, 4'b1111, "t3g3");
        run_frame(8'h44, 4'b0000, 1'b0, "t3f3");
        wait_grant(4'b0001, 0, 0, 4'b0000, "t3g0b");
        run_frame(8'h11, 4'b0000, 1'b0, "t3f0b");

        // 4. Fairness: after 1, {1,3} valid -> 3; 0 arrives during 3 -> 0; then 1.
        rstn  = 1'b0;
        valid = 4'b0010;
        data  = 32'h8C4B_2ED7;
        step();
        step();
        rstn  = 1'b1;
        wait_grant(4'b0010, 1, 0, 4'b1010, "t4g1");
        run_frame(8'h2E, 4'b0000, 1'b0, "t4f1");
        wait_grant(4'b1000, 3, 0, 4'b0011, "t4g3");
        run_frame(8'h8C, 4'b0000, 1'b0, "t4f3");
        wait_grant(4'b0001, 0, 0, 4'b0010, "t4g0");
        run_frame(8'hD7, 4'b0000, 1'b0, "t4f0");
        wait_grant(4'b0010, 1, 0, 4'b0000, "t4g1b");
        run_frame(8'h2E, 4'b0000, 1'b0, "t4f1b");

        // 5. Reset during data bit 4 of 0xEF from requester 0.
        data  = 32'h004B_3CEF;
        valid = 4'b0001;
        wait_grant(4'b0001, 0, 0, 4'b0000, "t5g0");
        advance_ce(44);
        check("t5_pre_tx_bit4", 32'(tx), 32'd0);
        check("t5_pre_busy", 32'(busy), 32'd1);
        valid = 4'b0110;
        rstn  = 1'b0;
        #1;
        check("t5_rst_tx", 32'(tx), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_ready", 32'(ready), 32'd0);
        bad = 0;
        repeat (3) begin
            step();
            if (done !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("t5_rst_hold_bad", 32'(bad), 32'd0);
        rstn = 1'b1;
        wait_grant(4'b0010, 1, 0, 4'b0100, "t5g1");
        run_frame(8'h3C, 4'b0000, 1'b0, "t5f1");

        // 6. Requester 3 glitches valid during frame 2, later sends 0x00.
        wait_grant(4'b0100, 2, 0, 4'b0000, "t6g2");
        run_frame(8'h4B, 4'b1000, 1'b0, "t6f2");
        bad = 0;
        repeat (20) begin
            if (ready !== 4'b0000 || busy !== 1'b0) bad++;
            step();
        end
        check("t6_no_capture_bad", 32'(bad), 32'd0);
        check("t6_gnt_kept", 32'(gnt), 32'd2);
        data  = 32'h004B_3CEF;
        valid = 4'b1000;
        wait_grant(4'b1000, 3, 0, 4'b0000, "t6g3");
        run_frame(8'h00, 4'b0000, 1'b1, "t6f3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
